// File: rtl/arb_pkg.sv
// Shared widths, arbiter state encoding and the rotate helper used by the round-robin search.
// Purely declarative: no logic, no latency, no flow control.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    // Bit j of the result is v[(j + amt) mod N_REQ], so the requester at 'amt' lands in bit 0.
    function automatic logic [N_REQ-1:0] rotr(input logic [N_REQ-1:0] v,
                                              input logic [IDX_W-1:0] amt);
        logic [2*N_REQ-1:0] w_dbl;
        w_dbl = {v, v} >> amt;
        return w_dbl[N_REQ-1:0];
    endfunction

endpackage

// File: rtl/onehot_enc_8to3.sv
// One-hot to binary encoder; combinational, zero latency, no flow control.
// Input must be one-hot or zero; zero encodes to index 0.
module onehot_enc_8to3
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] i_onehot,
    output logic [IDX_W-1:0] o_idx
);

    always_comb begin
        o_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (i_onehot[k]) begin
                o_idx = o_idx | IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with owner lock and hold-time limit; grant visible 1 cycle after req.
// No backpressure: an owner keeps the grant until it drops req or MAX_HOLD cycles elapse.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] w_owner_nxt;
    logic [IDX_W-1:0] r_last;
    logic [IDX_W-1:0] w_last_nxt;
    logic [7:0]       r_hold_cnt;
    logic [7:0]       w_hold_nxt;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] w_gnt_nxt;
    logic [IDX_W-1:0] r_gnt_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             r_gnt_valid;
    logic             w_vld_nxt;

    logic [IDX_W-1:0] w_start;
    logic [IDX_W-1:0] w_pick;
    logic [IDX_W-1:0] w_win;
    logic [N_REQ-1:0] w_rot;
    logic [N_REQ-1:0] w_win_oh;
    logic             w_found;
    logic             w_arb;

    // Search starts one past the last winner; while OWNED, last == owner, so the owner comes last.
    assign w_start = r_last + 3'd1;
    assign w_rot   = rotr(req, w_start);

    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_pick  = IDX_W'(j);
                w_found = 1'b1;
            end
        end
    end

    assign w_win    = w_start + w_pick;
    assign w_win_oh = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_hold_nxt  = r_hold_cnt;
        w_gnt_nxt   = r_gnt;
        w_vld_nxt   = r_gnt_valid;
        w_arb       = 1'b0;

        case (r_state)
            IDLE: begin
                w_arb = 1'b1;
            end
            OWNED: begin
                // Release and timeout share the same re-arbitration; release wins if both hold.
                if (!req[r_owner] || (r_hold_cnt == HOLD_LAST)) begin
                    w_arb = 1'b1;
                end else begin
                    w_hold_nxt = r_hold_cnt + 8'd1;
                end
            end
        endcase

        if (w_arb) begin
            w_hold_nxt = 8'd0;
            if (w_found) begin
                w_state_nxt = OWNED;
                w_owner_nxt = w_win;
                w_last_nxt  = w_win;
                w_gnt_nxt   = w_win_oh;
                w_vld_nxt   = 1'b1;
            end else begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_vld_nxt   = 1'b0;
            end
        end
    end

    onehot_enc_8to3 u_enc (
        .i_onehot (w_gnt_nxt),
        .o_idx    (w_idx_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_last      <= 3'd7;
            r_hold_cnt  <= 8'd0;
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_last      <= w_last_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_idx   <= w_idx_nxt;
            r_gnt_valid <= w_vld_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8 with MAX_HOLD=4: vector table, rotation and reset sequences,
// and a long random run against a reference model with fairness and encoding invariants.
module tb_rr_arbiter_8;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    int n_pass = 0;
    int n_chk  = 0;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       vld;
    } exp_t;

    typedef struct packed {
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       vld;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[28];

    int m_owner;
    int m_last;
    int m_hold;

    always #5 clk = ~clk;

    rr_arbiter_8 #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic chk_le(input string nm, input int act, input int lim);
        n_chk++;
        if (act <= lim) n_pass++;
        else $display("FAIL %s: got %0d limit %0d at %0t", nm, act, lim, $time);
    endtask

    function automatic vec_t mkv(input logic [7:0] r, input logic [7:0] g,
                                 input logic [2:0] i, input logic v);
        vec_t t;
        t.req = r; t.gnt = g; t.idx = i; t.vld = v;
        return t;
    endfunction

    function automatic exp_t mke(input logic [7:0] g, input logic [2:0] i, input logic v);
        exp_t e;
        e.gnt = g; e.idx = i; e.vld = v;
        return e;
    endfunction

    // Reference model: walk candidates one by one after the last winner.
    function automatic exp_t model_step(input logic [7:0] r);
        int cand;
        if (m_owner < 0 || !r[m_owner] || m_hold == MH - 1) begin
            m_owner = -1;
            for (int k = 1; k <= 8; k++) begin
                cand = (m_last + k) % 8;
                if (m_owner < 0 && r[cand]) m_owner = cand;
            end
            m_hold = 0;
            if (m_owner >= 0) m_last = m_owner;
        end else begin
            m_hold++;
        end
        if (m_owner >= 0) return mke(8'(1 << m_owner), 3'(m_owner), 1'b1);
        return mke(8'h00, 3'd0, 1'b0);
    endfunction

    // Called at a negedge: drive req, let one rising edge pass, return at the next negedge.
    task automatic drive(input logic [7:0] r);
        req = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_sb(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            chk({nm, " sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        chk({nm, " gnt"}, int'(gnt), int'(e.gnt));
        chk({nm, " idx"}, int'(gnt_idx), int'(e.idx));
        chk({nm, " vld"}, int'(gnt_valid), int'(e.vld));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00;
        @(negedge clk);
        chk("reset gnt", int'(gnt), 0);
        chk("reset idx", int'(gnt_idx), 0);
        chk("reset vld", int'(gnt_valid), 0);
        rst = 1'b0;
        m_owner = -1;
        m_last  = 7;
        m_hold  = 0;
        sb.delete();
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] mask;
        logic [7:0] last_g;
        int         run;
        int         wait_c[8];
        int         maxw;
        exp_t       e;
        int         cur;
        int         prv;

        for (int i = 0; i < 5; i++) tbl[i] = mkv(8'h00, 8'h00, 3'd0, 1'b0);
        tbl[5]  = mkv(8'h81, 8'h01, 3'd0, 1'b1);
        tbl[6]  = mkv(8'h80, 8'h80, 3'd7, 1'b1);
        tbl[7]  = mkv(8'h80, 8'h80, 3'd7, 1'b1);
        tbl[8]  = mkv(8'h00, 8'h00, 3'd0, 1'b0);
        tbl[9]  = mkv(8'hFF, 8'h01, 3'd0, 1'b1);
        tbl[10] = mkv(8'hFF, 8'h01, 3'd0, 1'b1);
        tbl[11] = mkv(8'hFE, 8'h02, 3'd1, 1'b1);
        tbl[12] = mkv(8'hFE, 8'h02, 3'd1, 1'b1);
        tbl[13] = mkv(8'hFC, 8'h04, 3'd2, 1'b1);
        tbl[14] = mkv(8'h06, 8'h04, 3'd2, 1'b1);
        tbl[15] = mkv(8'h06, 8'h04, 3'd2, 1'b1);
        tbl[16] = mkv(8'h06, 8'h04, 3'd2, 1'b1);
        tbl[17] = mkv(8'h06, 8'h02, 3'd1, 1'b1);
        tbl[18] = mkv(8'h06, 8'h02, 3'd1, 1'b1);
        tbl[19] = mkv(8'h06, 8'h02, 3'd1, 1'b1);
        tbl[20] = mkv(8'h06, 8'h02, 3'd1, 1'b1);
        tbl[21] = mkv(8'h06, 8'h04, 3'd2, 1'b1);
        for (int i = 22; i < 28; i++) tbl[i] = mkv(8'h02, 8'h02, 3'd1, 1'b1);

        // Directed vectors: idle, release hand-off, drop to idle, hold limit, lone-owner re-grant.
        do_reset();
        for (int i = 0; i < 28; i++) begin
            sb.push_back(mke(tbl[i].gnt, tbl[i].idx, tbl[i].vld));
            drive(tbl[i].req);
            check_sb($sformatf("vec%0d", i));
        end

        // All requesting; each owner drops its bit after two granted cycles.
        do_reset();
        for (int k = 0; k <= 8; k++) begin
            cur = k % 8;
            prv = (k + 7) % 8;
            r = (k == 0) ? 8'hFF : (8'hFF & ~(8'(1 << prv)));
            sb.push_back(mke(8'(1 << cur), 3'(cur), 1'b1));
            drive(r);
            check_sb($sformatf("rot%0d a", k));
            sb.push_back(mke(8'(1 << cur), 3'(cur), 1'b1));
            drive(8'hFF);
            check_sb($sformatf("rot%0d b", k));
        end

        // Reset pulse in the middle of owner 3's hold.
        do_reset();
        drive(8'h18);
        chk("mid grant", int'(gnt), 8'h08);
        drive(8'h18);
        chk("mid hold", int'(gnt), 8'h08);
        rst = 1'b1;
        #1;
        chk("async gnt", int'(gnt), 0);
        chk("async idx", int'(gnt_idx), 0);
        chk("async vld", int'(gnt_valid), 0);
        #3;
        rst = 1'b0;
        @(negedge clk);
        chk("post gnt", int'(gnt), 8'h08);
        chk("post idx", int'(gnt_idx), 3);
        chk("post vld", int'(gnt_valid), 1);

        // Random run: bits toggle rarely so owners tend to hit the hold limit.
        do_reset();
        r = 8'h00;
        last_g = 8'h00;
        run = 0;
        for (int k = 0; k < 8; k++) wait_c[k] = 0;
        for (int c = 0; c < 10000; c++) begin
            mask = 8'($urandom) & 8'($urandom) & 8'($urandom);
            r = r ^ mask;
            e = model_step(r);
            sb.push_back(e);
            drive(r);
            check_sb("rand");
            chk_le("onehot0", $countones(gnt), 1);
            chk("idx vs gnt", int'(gnt), gnt_valid ? (1 << gnt_idx) : 0);
            chk("vld vs gnt", int'(gnt_valid), int'(gnt != 8'h00));
            if (gnt != 8'h00 && gnt == last_g && (r & ~gnt) != 8'h00) run++;
            else run = (gnt != 8'h00) ? 1 : 0;
            last_g = gnt;
            chk_le("hold limit", run, MH);
            maxw = 0;
            for (int k = 0; k < 8; k++) begin
                if (r[k] && !gnt[k]) wait_c[k]++;
                else wait_c[k] = 0;
                if (wait_c[k] > maxw) maxw = wait_c[k];
            end
            chk_le("starvation", maxw, 7 * MH);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
